// File: rtl/adder_sched_pkg.sv
// Shared types, constants and helpers for the nibble-serial adder scheduler.
package adder_sched_pkg;

    localparam int unsigned SLICE_W = 4;
    localparam int unsigned MAX_REQ = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int unsigned nnib(input int unsigned width);
        return width / SLICE_W;
    endfunction

    // First set bit of valid at or above ptr, wrapping modulo n.
    function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned idx;
        int unsigned pick;
        logic        found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            if (!found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/adder_slice_sched_if.sv
// Request/response bundle between operand producers and the adder scheduler.
interface adder_slice_sched_if #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned ID_W = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
    );

endinterface

// File: rtl/adder_slice4.sv
// Combinational 4-bit ripple-carry slice built from full_adder cells.
module adder_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end

    assign cout = c[4];
endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/adder_slice_sched.sv
// Round-robin scheduler sharing one 4-bit adder slice for nibble-serial
// WIDTH-bit additions across NREQ requesters.
module adder_slice_sched
    import adder_sched_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst,
    adder_slice_sched_if.slave  bus
);
    localparam int unsigned NNIB  = nnib(WIDTH);
    localparam int unsigned NIB_W = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam int unsigned ID_W  = $clog2(NREQ);

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    grant;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic [NIB_W-1:0]   nib;
    logic               any_req;
    logic [SLICE_W-1:0] a_nib;
    logic [SLICE_W-1:0] b_nib;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_cout;

    assign any_req = |bus.req_valid;
    assign grant   = ID_W'(rr_pick(MAX_REQ'(bus.req_valid), 32'(rr_ptr), NREQ));

    always_comb begin
        a_nib = a_q[nib*SLICE_W +: SLICE_W];
        b_nib = b_q[nib*SLICE_W +: SLICE_W];
    end

    adder_slice4 u_slice (
        .a   (a_nib),
        .b   (b_nib),
        .cin (carry_q),
        .s   (slice_s),
        .cout(slice_cout)
    );

    // req_ready is gated by rst so the accept strobe is quiet while reset is held.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                if (any_req && !rst) begin
                    bus.req_ready[grant] = 1'b1;
                    state_nxt            = RUN;
                end
            end
            RUN: begin
                if (nib == NIB_W'(NNIB - 1)) state_nxt = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            nib     <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        a_q     <= bus.req_a[grant*WIDTH +: WIDTH];
                        b_q     <= bus.req_b[grant*WIDTH +: WIDTH];
                        carry_q <= bus.req_cin[grant];
                        id_q    <= grant;
                        nib     <= '0;
                    end
                end
                RUN: begin
                    sum_q[nib*SLICE_W +: SLICE_W] <= slice_s;
                    carry_q                       <= slice_cout;
                    nib                           <= nib + 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready)
                        rr_ptr <= (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = carry_q;
    assign bus.rsp_id    = id_q;
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_adder_slice_sched.sv
// Directed self-checking bench for adder_slice_sched (NREQ=4, WIDTH=16).
module tb_adder_slice_sched;

    logic clk;
    logic rst;
    int   checks;
    int   passes;
    int   g;
    int   lat;

    adder_slice_sched_if #(.NREQ(4), .WIDTH(16)) bus ();

    adder_slice_sched #(.NREQ(4), .WIDTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic request(input int r, input logic [15:0] a, input logic [15:0] b, input logic cin);
        bus.req_a[r*16 +: 16] = a;
        bus.req_b[r*16 +: 16] = b;
        bus.req_cin[r]        = cin;
        bus.req_valid[r]      = 1'b1;
    endtask

    // Waits for a grant, then drops that requester's valid just after the accept edge.
    task automatic await_grant(output int gi);
        logic seen;
        seen = 1'b0;
        gi   = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.req_ready != 4'b0) begin
                seen = 1'b1;
                for (int j = 0; j < 4; j++) if (bus.req_ready[j]) gi = j;
            end
        end
        check("grant_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("ready_onehot", 32'($countones(bus.req_ready)), 32'd1);
            @(posedge clk);
            #1;
            bus.req_valid[gi] = 1'b0;
        end
    endtask

    // Counts edges after the accept edge until rsp_valid is seen.
    task automatic await_rsp(output int l);
        logic seen;
        seen = 1'b0;
        l    = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            l++;
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("rsp_seen", 32'(seen), 32'd1);
    endtask

    task automatic txn(input int exp_g, input logic [15:0] exp_sum, input logic exp_cout);
        await_grant(g);
        check("grant_id", 32'(g), 32'(exp_g));
        await_rsp(lat);
        check("latency", 32'(lat), 32'd4);
        check("rsp_sum", 32'(bus.rsp_sum), 32'(exp_sum));
        check("rsp_cout", 32'(bus.rsp_cout), 32'(exp_cout));
        check("rsp_id", 32'(bus.rsp_id), 32'(exp_g));
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        passes        = 0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        bus.rsp_ready = 1'b1;

        @(negedge clk);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("rst_rsp_cout", 32'(bus.rsp_cout), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single add, plus RUN-phase status
        request(0, 16'h1234, 16'h4321, 1'b0);
        await_grant(g);
        check("grant_id", 32'(g), 32'd0);
        @(negedge clk);
        check("run_busy", 32'(bus.busy), 32'd1);
        check("run_req_ready", 32'(bus.req_ready), 32'd0);
        check("run_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        await_rsp(lat);
        check("latency", 32'(lat), 32'd3);
        check("rsp_sum", 32'(bus.rsp_sum), 32'h5555);
        check("rsp_cout", 32'(bus.rsp_cout), 32'd0);
        check("rsp_id", 32'(bus.rsp_id), 32'd0);
        @(posedge clk);
        #1;
        check("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("done_busy", 32'(bus.busy), 32'd0);

        // Carry ripple (rr_ptr=1, then 3)
        request(2, 16'hFFFF, 16'h0001, 1'b0);
        txn(2, 16'h0000, 1'b1);
        request(3, 16'hFFFF, 16'hFFFF, 1'b1);
        txn(3, 16'hFFFF, 1'b1);

        // Round robin from a fresh reset with all four pending
        rst = 1'b1;
        #2;
        rst = 1'b0;
        request(0, 16'h0001, 16'h0002, 1'b0);
        request(1, 16'h00F0, 16'h0F10, 1'b0);
        request(2, 16'h8000, 16'h8000, 1'b0);
        request(3, 16'h1111, 16'h2222, 1'b1);
        txn(0, 16'h0003, 1'b0);
        txn(1, 16'h1000, 1'b0);
        txn(2, 16'h0000, 1'b1);
        txn(3, 16'h3334, 1'b0);

        // rr_ptr wrapped to 0: 1 wins over 3
        request(1, 16'h0005, 16'h0006, 1'b0);
        request(3, 16'h7FFF, 16'h0001, 1'b0);
        txn(1, 16'h000B, 1'b0);
        txn(3, 16'h8000, 1'b0);

        // Backpressure with a competing request pending during RESP
        bus.rsp_ready = 1'b0;
        request(2, 16'h0ABC, 16'h0111, 1'b0);
        await_grant(g);
        check("bp_grant", 32'(g), 32'd2);
        request(0, 16'h0000, 16'h0000, 1'b1);
        await_rsp(lat);
        check("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_sum", 32'(bus.rsp_sum), 32'h0BCD);
            check("bp_rsp_id", 32'(bus.rsp_id), 32'd2);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_done", 32'(bus.rsp_valid), 32'd0);
        txn(0, 16'h0001, 1'b0);

        // Reset at nib=2; rr_ptr was 1 before reset
        request(3, 16'h1111, 16'h1111, 1'b0);
        await_grant(g);
        check("mid_grant", 32'(g), 32'd3);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid_busy_pre", 32'(bus.busy), 32'd1);
        request(0, 16'h0F0F, 16'hF0F1, 1'b0);
        request(1, 16'h1234, 16'h0000, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("mid_rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
        check("mid_rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("mid_rst_rsp_cout", 32'(bus.rsp_cout), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        txn(0, 16'h0000, 1'b1);
        txn(1, 16'h1235, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
